// File: rtl/button_code_lock_pkg.sv
// Shared types for the button combination lock: FSM states, press symbols, default code.
// Latency: n/a (types and a combinational decode helper); backpressure: n/a.
package button_code_lock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        FAIL    = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4
    } lock_state_t;

    typedef logic [1:0] sym_t;

    typedef struct packed {
        logic vld;
        sym_t sym;
    } press_t;

    // Symbol 0 in the low bits is entered first: sequence 0,1,2,3.
    localparam logic [13:0] DEFAULT_CODE = 14'b00_0000_11_10_01_00;

    // Only a strictly one-hot pulse set is a press; chords are dropped.
    function automatic press_t decode_press(input logic [3:0] x);
        press_t p;
        p.vld = 1'b1;
        p.sym = 2'd0;
        case (x)
            4'b0001: p.sym = 2'd0;
            4'b0010: p.sym = 2'd1;
            4'b0100: p.sym = 2'd2;
            4'b1000: p.sym = 2'd3;
            default: p.vld = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/button_code_lock_timer.sv
// Shared down-counter timer; expired is high while active and count <= 1 (a load of 0 expires at once).
// Latency: expired rises N cycles after a load of N; backpressure: none, load wins over clear/expiry.
module lock_timer #(
    parameter int TMR_W = 24
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             clear,
    output logic             expired
);

    logic [TMR_W-1:0] count;
    logic             active;

    assign expired = active && (count <= TMR_W'(1));

    always_ff @(posedge sysclk) begin
        if (reset) begin
            count  <= '0;
            active <= 1'b0;
        end else if (load) begin
            count  <= load_val;
            active <= 1'b1;
        end else if (clear || expired) begin
            count  <= '0;
            active <= 1'b0;
        end else if (active) begin
            count  <= count - TMR_W'(1);
        end
    end

endmodule

// File: rtl/button_code_lock.sv
// Combination lock over one-hot debounced button pulses with fail counting and timed lockout.
// Latency: all outputs registered, a press at t is visible at t+1; backpressure: none, presses outside IDLE/ENTRY are dropped.
module button_code_lock
    import button_code_lock_pkg::*;
#(
    parameter int               CODE_LEN      = 4,
    parameter logic [13:0]      CODE          = DEFAULT_CODE,
    parameter int               MAX_FAIL      = 3,
    parameter int               TMR_W         = 24,
    parameter logic [TMR_W-1:0] ENTRY_TIMEOUT = TMR_W'(10_000_000),
    parameter logic [TMR_W-1:0] OPEN_TIME     = TMR_W'(15_000_000),
    parameter logic [TMR_W-1:0] LOCKOUT_TIME  = TMR_W'(16_000_000)
) (
    input  logic                                sysclk,
    input  logic                                reset,
    input  logic                                X0_deb,
    input  logic                                X1_deb,
    input  logic                                X2_deb,
    input  logic                                X3_deb,
    input  logic                                lock_req,
    output logic                                unlocked,
    output logic                                locked_out,
    output logic                                err_pulse,
    output logic [$clog2(CODE_LEN+1)-1:0]       digits_entered,
    output logic [$clog2(MAX_FAIL+1)-1:0]       fail_count
);

    localparam int DW = $clog2(CODE_LEN + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam logic [DW-1:0] LAST_IDX   = DW'(CODE_LEN - 1);
    localparam logic [FW:0]   MAX_FAIL_W = (FW + 1)'(MAX_FAIL);

    lock_state_t      state, next_state;
    press_t           press;
    sym_t             exp_sym;
    logic             match_q, match_n, cur_match;
    logic             err_n;
    logic [DW-1:0]    digits_n;
    logic [FW-1:0]    fail_n;
    logic [FW:0]      fail_inc;
    logic             tmr_load, tmr_clear, tmr_expired;
    logic [TMR_W-1:0] tmr_val;

    assign press    = decode_press({X3_deb, X2_deb, X1_deb, X0_deb});
    assign fail_inc = {1'b0, fail_count} + (FW + 1)'(1);

    lock_timer #(.TMR_W(TMR_W)) u_timer (
        .sysclk   (sysclk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .clear    (tmr_clear),
        .expired  (tmr_expired)
    );

    always_comb begin
        exp_sym = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (digits_entered == DW'(i)) exp_sym = CODE[2*i +: 2];
        end
    end

    // digits_entered is 0 in IDLE, so IDLE and ENTRY share one press path.
    assign cur_match = ((state == IDLE) ? 1'b1 : match_q) && (press.sym == exp_sym);

    always_comb begin
        next_state = state;
        digits_n   = digits_entered;
        fail_n     = fail_count;
        match_n    = match_q;
        err_n      = 1'b0;
        tmr_load   = 1'b0;
        tmr_clear  = 1'b0;
        tmr_val    = '0;
        case (state)
            IDLE, ENTRY: begin
                if (press.vld) begin
                    match_n = cur_match;
                    if (digits_entered == LAST_IDX) begin
                        digits_n = '0;
                        if (cur_match) begin
                            next_state = OPEN;
                            fail_n     = '0;
                            tmr_load   = 1'b1;
                            tmr_val    = OPEN_TIME;
                        end else if (fail_inc < MAX_FAIL_W) begin
                            next_state = FAIL;
                            fail_n     = fail_inc[FW-1:0];
                            err_n      = 1'b1;
                            tmr_clear  = 1'b1;
                        end else begin
                            next_state = LOCKOUT;
                            fail_n     = FW'(MAX_FAIL);
                            err_n      = 1'b1;
                            tmr_load   = 1'b1;
                            tmr_val    = LOCKOUT_TIME;
                        end
                    end else begin
                        next_state = ENTRY;
                        digits_n   = digits_entered + DW'(1);
                        tmr_load   = 1'b1;
                        tmr_val    = ENTRY_TIMEOUT;
                    end
                end else if (state == ENTRY && tmr_expired) begin
                    next_state = IDLE;
                    digits_n   = '0;
                    tmr_clear  = 1'b1;
                end
            end
            FAIL: begin
                next_state = IDLE;
            end
            OPEN: begin
                if (lock_req || tmr_expired) begin
                    next_state = IDLE;
                    tmr_clear  = 1'b1;
                end
            end
            LOCKOUT: begin
                if (tmr_expired) begin
                    next_state = IDLE;
                    fail_n     = '0;
                    tmr_clear  = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                digits_n   = '0;
                tmr_clear  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state          <= IDLE;
            match_q        <= 1'b0;
            unlocked       <= 1'b0;
            locked_out     <= 1'b0;
            err_pulse      <= 1'b0;
            digits_entered <= '0;
            fail_count     <= '0;
        end else begin
            state          <= next_state;
            match_q        <= match_n;
            unlocked       <= (next_state == OPEN);
            locked_out     <= (next_state == LOCKOUT);
            err_pulse      <= err_n;
            digits_entered <= digits_n;
            fail_count     <= fail_n;
        end
    end

endmodule

// File: tb/tb_button_code_lock.sv
// Directed bench for button_code_lock with short timer values (entry 20, open 50, lockout 30).
module tb_button_code_lock;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic       X0_deb = 1'b0, X1_deb = 1'b0, X2_deb = 1'b0, X3_deb = 1'b0;
    logic       lock_req = 1'b0;
    logic       unlocked, locked_out, err_pulse;
    logic [2:0] digits_entered;
    logic [1:0] fail_count;

    int n_cmp = 0;
    int n_bad = 0;
    int errs  = 0;

    button_code_lock #(
        .ENTRY_TIMEOUT (24'd20),
        .OPEN_TIME     (24'd50),
        .LOCKOUT_TIME  (24'd30),
        .MAX_FAIL      (3)
    ) dut (
        .sysclk         (sysclk),
        .reset          (reset),
        .X0_deb         (X0_deb),
        .X1_deb         (X1_deb),
        .X2_deb         (X2_deb),
        .X3_deb         (X3_deb),
        .lock_req       (lock_req),
        .unlocked       (unlocked),
        .locked_out     (locked_out),
        .err_pulse      (err_pulse),
        .digits_entered (digits_entered),
        .fail_count     (fail_count)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) if (err_pulse === 1'b1) errs++;

    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) cyc();
    endtask

    task automatic pulse(input logic [3:0] x);
        {X3_deb, X2_deb, X1_deb, X0_deb} = x;
        cyc();
        {X3_deb, X2_deb, X1_deb, X0_deb} = 4'b0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        gap(2);
        reset = 1'b0;
    endtask

    // Presses four symbols with sp cycles between successive press edges.
    task automatic enter4(input logic [1:0] s0, input logic [1:0] s1,
                          input logic [1:0] s2, input logic [1:0] s3, input int sp);
        pulse(4'b0001 << s0); gap(sp - 1);
        pulse(4'b0001 << s1); gap(sp - 1);
        pulse(4'b0001 << s2); gap(sp - 1);
        pulse(4'b0001 << s3);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL reset_unlocked got %b want 0", unlocked); end
        n_cmp++; if (locked_out !== 1'b0) begin n_bad++; $display("FAIL reset_locked_out got %b want 0", locked_out); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err_pulse); end
        n_cmp++; if (digits_entered !== 3'd0) begin n_bad++; $display("FAIL reset_digits got %0d want 0", digits_entered); end
        n_cmp++; if (fail_count !== 2'd0) begin n_bad++; $display("FAIL reset_fail_count got %0d want 0", fail_count); end
    endtask

    task automatic test_correct_code();
        int base;
        int hi;
        do_reset();
        base = errs;
        enter4(2'd0, 2'd1, 2'd2, 2'd3, 5);
        n_cmp++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL open_unlocked got %b want 1", unlocked); end
        n_cmp++; if (fail_count !== 2'd0) begin n_bad++; $display("FAIL open_fail_count got %0d want 0", fail_count); end
        n_cmp++; if (digits_entered !== 3'd0) begin n_bad++; $display("FAIL open_digits got %0d want 0", digits_entered); end
        hi = 0;
        for (int i = 0; i < 49; i++) begin
            cyc();
            if (unlocked === 1'b1) hi++;
        end
        n_cmp++; if (hi !== 49) begin n_bad++; $display("FAIL open_hold got %0d more cycles high want 49", hi); end
        cyc();
        n_cmp++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL open_relock got %b want 0", unlocked); end
        n_cmp++; if (errs !== base) begin n_bad++; $display("FAIL open_no_err got %0d err cycles want 0", errs - base); end
    endtask

    task automatic test_wrong_code();
        do_reset();
        pulse(4'b0001);
        n_cmp++; if (digits_entered !== 3'd1) begin n_bad++; $display("FAIL wrong_digits1 got %0d want 1", digits_entered); end
        gap(4); pulse(4'b0010);
        n_cmp++; if (digits_entered !== 3'd2) begin n_bad++; $display("FAIL wrong_digits2 got %0d want 2", digits_entered); end
        gap(4); pulse(4'b1000);
        n_cmp++; if (digits_entered !== 3'd3) begin n_bad++; $display("FAIL wrong_digits3 got %0d want 3", digits_entered); end
        gap(4); pulse(4'b0100);
        n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL wrong_err got %b want 1", err_pulse); end
        n_cmp++; if (fail_count !== 2'd1) begin n_bad++; $display("FAIL wrong_fail_count got %0d want 1", fail_count); end
        n_cmp++; if (digits_entered !== 3'd0) begin n_bad++; $display("FAIL wrong_digits4 got %0d want 0", digits_entered); end
        n_cmp++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL wrong_unlocked got %b want 0", unlocked); end
        cyc();
        n_cmp++; if (err_pulse !== 1'b0) begin n_bad++; $display("FAIL wrong_err_width got %b want 0", err_pulse); end
    endtask

    task automatic test_lockout();
        int bad;
        do_reset();
        enter4(2'd0, 2'd1, 2'd3, 2'd2, 2); gap(2);
        enter4(2'd0, 2'd1, 2'd3, 2'd2, 2);
        n_cmp++; if (fail_count !== 2'd2) begin n_bad++; $display("FAIL lock_fail2 got %0d want 2", fail_count); end
        gap(2);
        enter4(2'd0, 2'd1, 2'd3, 2'd2, 2);
        n_cmp++; if (locked_out !== 1'b1) begin n_bad++; $display("FAIL lock_entered got %b want 1", locked_out); end
        n_cmp++; if (fail_count !== 2'd3) begin n_bad++; $display("FAIL lock_fail3 got %0d want 3", fail_count); end
        n_cmp++; if (err_pulse !== 1'b1) begin n_bad++; $display("FAIL lock_err got %b want 1", err_pulse); end
        bad = 0;
        for (int i = 1; i < 30; i++) begin
            X0_deb = (i % 5 == 0);
            lock_req = (i == 7);
            cyc();
            X0_deb = 1'b0;
            lock_req = 1'b0;
            if (locked_out !== 1'b1 || digits_entered !== 3'd0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL lock_hold got %0d bad cycles want 0", bad); end
        cyc();
        n_cmp++; if (locked_out !== 1'b0) begin n_bad++; $display("FAIL lock_expire got %b want 0", locked_out); end
        n_cmp++; if (fail_count !== 2'd0) begin n_bad++; $display("FAIL lock_fail_clear got %0d want 0", fail_count); end
        enter4(2'd0, 2'd1, 2'd2, 2'd3, 3);
        n_cmp++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL lock_then_open got %b want 1", unlocked); end
    endtask

    task automatic test_entry_timeout();
        int held;
        do_reset();
        enter4(2'd0, 2'd1, 2'd3, 2'd2, 2); gap(2);
        pulse(4'b0001); gap(4);
        pulse(4'b0010);
        held = 0;
        for (int i = 0; i < 19; i++) begin
            cyc();
            if (digits_entered === 3'd2) held++;
        end
        n_cmp++; if (held !== 19) begin n_bad++; $display("FAIL tmo_hold got %0d cycles want 19", held); end
        cyc();
        n_cmp++; if (digits_entered !== 3'd0) begin n_bad++; $display("FAIL tmo_digits got %0d want 0", digits_entered); end
        n_cmp++; if (fail_count !== 2'd1) begin n_bad++; $display("FAIL tmo_fail_count got %0d want 1", fail_count); end
        gap(5);
        enter4(2'd0, 2'd1, 2'd2, 2'd3, 2);
        n_cmp++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL tmo_then_open got %b want 1", unlocked); end
        n_cmp++; if (fail_count !== 2'd0) begin n_bad++; $display("FAIL tmo_fail_clear got %0d want 0", fail_count); end
    endtask

    task automatic test_chord_and_reset();
        do_reset();
        pulse(4'b0011);
        n_cmp++; if (digits_entered !== 3'd0) begin n_bad++; $display("FAIL chord_digits got %0d want 0", digits_entered); end
        pulse(4'b0001);
        n_cmp++; if (digits_entered !== 3'd1) begin n_bad++; $display("FAIL chord_then_press got %0d want 1", digits_entered); end
        lock_req = 1'b1; cyc(); lock_req = 1'b0;
        n_cmp++; if (digits_entered !== 3'd1) begin n_bad++; $display("FAIL lockreq_entry got %0d want 1", digits_entered); end
        pulse(4'b0010);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_cmp++; if ({unlocked, locked_out, err_pulse, digits_entered, fail_count} !== 8'd0)
            begin n_bad++; $display("FAIL midreset got u%b l%b e%b d%0d f%0d want all 0",
                                    unlocked, locked_out, err_pulse, digits_entered, fail_count); end
    endtask

    task automatic test_relock();
        do_reset();
        enter4(2'd0, 2'd1, 2'd2, 2'd3, 1);
        gap(4);
        pulse(4'b0001);
        n_cmp++; if (digits_entered !== 3'd0 || unlocked !== 1'b1)
            begin n_bad++; $display("FAIL open_press got d%0d u%b want d0 u1", digits_entered, unlocked); end
        gap(4);
        n_cmp++; if (unlocked !== 1'b1) begin n_bad++; $display("FAIL relock_before got %b want 1", unlocked); end
        lock_req = 1'b1; cyc(); lock_req = 1'b0;
        n_cmp++; if (unlocked !== 1'b0) begin n_bad++; $display("FAIL relock got %b want 0", unlocked); end
    endtask

    task automatic test_recovery();
        do_reset();
        enter4(2'd3, 2'd1, 2'd2, 2'd3, 3);
        n_cmp++; if (fail_count !== 2'd1) begin n_bad++; $display("FAIL recov_fail got %0d want 1", fail_count); end
        gap(3);
        enter4(2'd0, 2'd1, 2'd2, 2'd3, 3);
        n_cmp++; if (unlocked !== 1'b1 || fail_count !== 2'd0)
            begin n_bad++; $display("FAIL recov_open got u%b f%0d want u1 f0", unlocked, fail_count); end
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_wrong_code();
        test_lockout();
        test_entry_timeout();
        test_chord_and_reset();
        test_relock();
        test_recovery();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/button_code_lock.md
Name: button_code_lock

Overview:
Consumes the four single-cycle, one-hot debounced button pulses X0_deb..X3_deb from the quad debouncer and runs a combination-lock state machine over them. It compares a sequence of CODE_LEN presses against a parameterised code, then reports unlock, failure and lockout status. It sits directly downstream of the debouncer and drives panel LEDs and the door-actuator enable.

Parameters:
CODE_LEN, 4, number of presses per attempt (1..7)
CODE, 8'b11_10_01_00, packed 2-bit symbols; symbol i at bits [2i+1:2i], i=0 entered first (default sequence 0,1,2,3)
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1)
TMR_W, 24, width of the shared cycle timer
ENTRY_TIMEOUT, 24'd10_000_000, idle cycles allowed between presses during entry
OPEN_TIME, 24'd15_000_000, cycles the lock stays open before auto-relock
LOCKOUT_TIME, 24'd16_000_000, cycles presses are ignored after MAX_FAIL failures

Ports:
sysclk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
X0_deb  in  1  debounced single-cycle press, symbol 0
X1_deb  in  1  debounced single-cycle press, symbol 1
X2_deb  in  1  debounced single-cycle press, symbol 2
X3_deb  in  1  debounced single-cycle press, symbol 3
lock_req  in  1  single-cycle request to relock while open
unlocked  out  1  high while in OPEN
locked_out  out  1  high while in LOCKOUT
err_pulse  out  1  one-cycle pulse on a failed attempt
digits_entered  out  $clog2(CODE_LEN+1)  presses accepted in the current attempt
fail_count  out  $clog2(MAX_FAIL+1)  consecutive failures

Behaviour:
- Reset: state IDLE; unlocked=0, locked_out=0, err_pulse=0, digits_entered=0, fail_count=0; timer and match flag cleared. Reset mid-operation abandons any attempt immediately.
- Press decode: press = exactly one Xn_deb high; sym = n. Two or more high in the same cycle is not a press and is ignored.
- All outputs are registered. Effects of a press at cycle t are visible at t+1.
- IDLE: a press moves to ENTRY, sets digits_entered=1, sets match=(sym==CODE[1:0]), and loads the timer with ENTRY_TIMEOUT.
- ENTRY, press, index k=digits_entered:
  - Set match &= (sym==CODE[2k+1:2k]) and increment digits_entered.
  - If k+1 < CODE_LEN, reload the timer.
  - If k+1 == CODE_LEN, evaluate:
    - match → OPEN, fail_count=0, timer=OPEN_TIME.
    - mismatch and fail_count+1 < MAX_FAIL → FAIL, fail_count++.
    - mismatch and fail_count+1 == MAX_FAIL → LOCKOUT, fail_count=MAX_FAIL, timer=LOCKOUT_TIME, err_pulse also asserted.
  - digits_entered returns to 0 on leaving ENTRY.
- ENTRY timer expiry with no press → IDLE, digits_entered=0. This is not a failure; fail_count is unchanged. If a press and expiry fall in the same cycle, the press wins.
- CODE_LEN=1: the first press from IDLE is evaluated directly, with the same outcomes as above.
- FAIL: lasts one cycle with err_pulse=1, then → IDLE.
- OPEN: unlocked=1 and presses are ignored. lock_req or timer expiry → IDLE; both in the same cycle → IDLE.
- LOCKOUT: locked_out=1; presses and lock_req are ignored. On timer expiry → IDLE with fail_count=0.
- Timer: down-counter. "Expiry" is the cycle count==1 while active, so the state holds for exactly N cycles after the transition cycle. Loading 0 counts as immediate expiry.
- lock_req outside OPEN has no effect.

Decomposition:
- Shared package button_code_lock_pkg:
  - state enum {IDLE, ENTRY, FAIL, OPEN, LOCKOUT}
  - 2-bit symbol typedef
  - default CODE constant
  - function decoding the four pulses into {valid, sym}
- One sub-module lock_timer (TMR_W): ports load, load_val, clear; output expired. Loaded by the FSM on state entry and on each ENTRY press.

Test Plan:
Bench uses ENTRY_TIMEOUT=20, OPEN_TIME=50, LOCKOUT_TIME=30, MAX_FAIL=3, CODE default.
- Correct code: pulses X0,X1,X2,X3 spaced 5 cycles apart → unlocked=1 the cycle after X3, held 50 cycles, then 0; fail_count=0; err_pulse never high.
- Wrong code: X0,X1,X3,X2 → err_pulse high exactly 1 cycle after X2, fail_count=1, digits_entered 1,2,3,4-press then 0, unlocked stays 0.
- Lockout: three wrong attempts → locked_out=1 after the third; presses during the next 30 cycles give digits_entered=0. After expiry, locked_out=0 and fail_count=0, and a correct code then opens.
- Entry timeout: X0,X1, then 25 idle cycles → digits_entered=0 at cycle 20 after X1, fail_count unchanged. A following correct sequence opens.
- Simultaneous/relock: X0&X1 high together → ignored, digits_entered=0. In OPEN, lock_req at cycle 10 → unlocked=0 next cycle. Reset asserted after 2 entry presses → all outputs 0 the next cycle.
- Recovery: one failure followed by a correct code → fail_count returns to 0 on open.
